// File: rtl/serial_full_sub.sv
`default_nettype none
// ============================================================================
// Module      : serial_full_sub
// Description : Bit-serial WIDTH-bit subtractor D = A - B - Bin, LSB first,
//               with start/done handshake. Optional signed-overflow output
//               OVF enabled by defining SERIAL_FULL_SUB_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_full_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
`ifdef SERIAL_FULL_SUB_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int              c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_SHIFT = 2'd1;
    localparam logic [1:0] c_S_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_r;
    logic             r_br;
    logic [c_CW-1:0]  r_cnt;

    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_r_next;
    logic             w_last;

    // Full-subtractor cell on the current LSBs.
    assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_last    = (r_cnt == c_LAST);

    generate
        if (WIDTH == 1) begin : g_r_narrow
            assign w_r_next = w_d;
        end else begin : g_r_wide
            assign w_r_next = {w_d, r_r[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE:  if (start) w_state_next = c_S_SHIFT;
            c_S_SHIFT: if (w_last) w_state_next = c_S_DONE;
            c_S_DONE:  w_state_next = c_S_IDLE;
            default:   w_state_next = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_r   <= '0;
            r_br  <= 1'b0;
            r_cnt <= '0;
            D     <= '0;
            Bout  <= 1'b0;
`ifdef SERIAL_FULL_SUB_OVF_EN
            OVF   <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_a   <= A;
                        r_b   <= B;
                        r_br  <= Bin;
                        r_cnt <= '0;
                    end
                end
                c_S_SHIFT: begin
                    r_a  <= r_a >> 1;
                    r_b  <= r_b >> 1;
                    r_br <= w_br_next;
                    r_r  <= w_r_next;
                    if (w_last) begin
                        // Counter parks at zero so it never passes WIDTH-1.
                        r_cnt <= '0;
                        D     <= w_r_next;
                        Bout  <= w_br_next;
`ifdef SERIAL_FULL_SUB_OVF_EN
                        OVF   <= r_br ^ w_br_next;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != c_S_IDLE);
    assign done = (r_state == c_S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_serial_full_sub.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_full_sub
// Description : Self-checking bench for serial_full_sub (WIDTH=8 and WIDTH=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_full_sub;

    typedef struct {
        logic [7:0] d;
        logic       bout;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start1;
    logic [7:0] a8, b8, d8;
    logic       bin8, busy8, done8, bout8, ovf8;
    logic [0:0] a1, b1, d1;
    logic       bin1, busy1, done1, bout1, ovf1;

    int checks   = 0;
    int failures = 0;

    exp_t q8[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    serial_full_sub #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Bin(bin8),
        .busy(busy8), .done(done8), .D(d8), .Bout(bout8)
`ifdef SERIAL_FULL_SUB_OVF_EN
        , .OVF(ovf8)
`endif
    );

    serial_full_sub #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .Bin(bin1),
        .busy(busy1), .done(done1), .D(d1), .Bout(bout1)
`ifdef SERIAL_FULL_SUB_OVF_EN
        , .OVF(ovf1)
`endif
    );

`ifndef SERIAL_FULL_SUB_OVF_EN
    assign ovf8 = 1'b0;
    assign ovf1 = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        exp_t e;
        logic [8:0] diff;
        int s;
        diff   = {1'b0, a} - {1'b0, b} - {8'd0, bin};
        s      = int'($signed(a)) - int'($signed(b)) - int'(bin);
        e.d    = diff[7:0];
        e.bout = diff[8];
        e.ovf  = (s < -128) || (s > 127);
        return e;
    endfunction

    // Scoreboard pop on done, sampled mid-cycle.
    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) begin
                check("w8_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("w8_D", 32'(d8), 32'(e.d));
                check("w8_Bout", 32'(bout8), 32'(e.bout));
`ifdef SERIAL_FULL_SUB_OVF_EN
                check("w8_OVF", 32'(ovf8), 32'(e.ovf));
`endif
            end
        end
        if (done1) begin
            if (q1.size() == 0) begin
                check("w1_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("w1_D", 32'(d1), 32'(e.d));
                check("w1_Bout", 32'(bout1), 32'(e.bout));
`ifdef SERIAL_FULL_SUB_OVF_EN
                check("w1_OVF", 32'(ovf1), 32'(e.ovf));
`endif
            end
        end
    end

    // Accept, then count edges to done; D/Bout must hold while shifting.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        int n;
        logic [7:0] d_hold;
        logic       bo_hold;
        @(negedge clk);
        a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
        q8.push_back(model8(a, b, bin));
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = ~a; b8 = ~b; bin8 = ~bin;
        check("w8_busy_after_accept", 32'(busy8), 32'd1);
        d_hold = d8; bo_hold = bout8;
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (done8) break;
            if (d8 !== d_hold || bout8 !== bo_hold)
                check("w8_D_stable_in_shift", {d8, 7'd0, bout8}, {d_hold, 7'd0, bo_hold});
        end
        check("w8_latency", 32'(n), 32'd8);
        @(posedge clk); #1;
        check("w8_idle_after_done", {busy8, done8}, 2'b00);
    endtask

    task automatic run1(input logic a, input logic b, input logic bin,
                        input logic ed, input logic ebo);
        exp_t e;
        int n;
        @(negedge clk);
        a1 = a; b1 = b; bin1 = bin; start1 = 1'b1;
        e.d = {7'd0, ed}; e.bout = ebo;
        e.ovf = ((-int'(a) + int'(b) - int'(bin)) < -1) || ((-int'(a) + int'(b) - int'(bin)) > 0);
        q1.push_back(e);
        @(posedge clk); #1;
        start1 = 1'b0;
        n = 0;
        while (n < 10) begin
            @(posedge clk); #1;
            n++;
            if (done1) break;
        end
        check("w1_latency", 32'(n), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("w8_reset_outputs", {busy8, done8, d8, bout8, ovf8}, 12'd0);
        check("w1_reset_outputs", {busy1, done1, d1, bout1, ovf1}, 5'd0);

        run8(8'h05, 8'h03, 1'b0);
        run8(8'h00, 8'h01, 1'b0);
        run8(8'h80, 8'h01, 1'b0);
        run8(8'h10, 8'h0F, 1'b1);
        run8(8'hFF, 8'hFF, 1'b1);
        run8(8'h7F, 8'hFF, 1'b0);

        // Re-pulse start mid-operation: must be ignored.
        @(negedge clk);
        a8 = 8'h09; b8 = 8'h04; bin8 = 1'b0; start8 = 1'b1;
        q8.push_back(model8(8'h09, 8'h04, 1'b0));
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (12) @(negedge clk);
        check("w8_repulse_drained", 32'(q8.size()), 32'd0);

        // Reset during the third SHIFT cycle cancels the operation.
        @(negedge clk);
        a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("w8_reset_mid_op", {busy8, done8, d8, bout8, ovf8}, 12'd0);
        repeat (10) @(negedge clk);
        run8(8'h02, 8'h03, 1'b0);

        // WIDTH=1: all eight {A,B,Bin} combinations.
        run1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run1(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        run1(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        run1(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        run1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        run1(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run1(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        repeat (3) @(negedge clk);
        check("w8_queue_empty", 32'(q8.size()), 32'd0);
        check("w1_queue_empty", 32'(q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
